// File: rtl/fir_frame_feeder.sv
// Stream adapter around a frame-phased FIR core: valid/ready FIFO in, one sample or zero
// bubble per frame into the FIR, tagged capture of the FIR result, valid/ready out.
module fir_frame_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int FRAME  = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [DATA_W-1:0]        fir_data_in_o,
    input  logic [DATA_W-1:0]        fir_data_out_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     phase_q, phase_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] fir_data_q, fir_data_d;
    logic [1:0]        tag_q, tag_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;

    logic full, empty, push, pop, pop_edge, cap_edge;

    // DEPTH is a power of two, so the level MSB is set exactly when the FIFO is full.
    assign full     = level_q[AW];
    assign empty    = (level_q == '0);
    assign pop_edge = (phase_q == PW'(FRAME - 1));
    assign cap_edge = (phase_q == '0);
    assign push     = in_valid_i && !full;
    assign pop      = pop_edge && !empty;

    assign in_ready_o    = !full;
    assign fir_data_in_o = fir_data_q;
    assign out_data_o    = out_data_q;
    assign out_valid_o   = out_valid_q;
    assign overflow_o    = overflow_q;
    assign fifo_level_o  = level_q;

    always_comb begin
        phase_d     = pop_edge ? '0 : phase_q + PW'(1);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q + LW'(push) - LW'(pop);
        fir_data_d  = fir_data_q;
        tag_d       = tag_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (pop_edge) begin
            fir_data_d = empty ? '0 : mem_q[rd_ptr_q];
            tag_d      = {tag_q[0], !empty};
        end

        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

        // A capture may reload the register on the same edge the old word leaves.
        if (cap_edge && tag_q[1]) begin
            if (!out_valid_q || out_ready_i) begin
                out_data_d  = fir_data_out_i;
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            fir_data_q  <= '0;
            tag_q       <= 2'b00;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            fir_data_q  <= fir_data_d;
            tag_q       <= tag_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
